// File: rtl/fsm_pattern_serializer_pkg.sv
// Shared definitions for the 101 pattern serializer: FSM encoding and the
// line pattern tracked by the golden hit detector.
package fsm_pattern_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] PATTERN_101 = 3'b101;

endpackage

// File: rtl/fsm_pattern_serializer_seq101_tracker.sv
// Overlapping 101 tracker on a serial line with a saturating, clearable hit
// counter; usable standalone as a reference model for the detector.
module seq101_tracker
  import fsm_pattern_serializer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] seq_hits
);

  // hist[1] is the older bit, hist[0] the bit seen on the previous clock
  logic [1:0] hist;

  assign hit = ({hist, line} == PATTERN_101);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist     <= 2'b00;
      seq_hits <= '0;
    end else begin
      hist <= {hist[0], line};
      if (clr)
        seq_hits <= '0;
      else if (hit && (seq_hits != {CNT_W{1'b1}}))
        seq_hits <= seq_hits + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_pattern_serializer.sv
// MSB-first word serializer with valid/ready load and a built-in 101 tracker
// watching the driven line.
//
// state | meaning
// IDLE  | line held at 0, ready for a word
// SHIFT | a word is on the line, bit_cnt counts WIDTH-1 down to 0
module fsm_pattern_serializer
  import fsm_pattern_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] seq_hits,
  input  logic             clr_hits
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             last;
  logic             accept;

  assign last       = (state == SHIFT) && (bit_cnt == '0);
  assign load_ready = (state == IDLE) || last;
  assign done       = last;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      // the MSB goes straight to the line; shreg keeps the remaining bits
      if (accept) begin
        state     <= SHIFT;
        bit_cnt   <= CW'(WIDTH - 1);
        shreg     <= {load_data[WIDTH-2:0], 1'b0};
        ser_out   <= load_data[WIDTH-1];
        ser_valid <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (last) begin
              state     <= IDLE;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
              ser_out <= shreg[WIDTH-1];
            end
          end
          default: begin
            state     <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  seq101_tracker #(.CNT_W(CNT_W)) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .line     (ser_out),
    .clr      (clr_hits),
    .hit      (hit),
    .seq_hits (seq_hits)
  );

endmodule

// File: tb/tb_fsm_pattern_serializer.sv
// Bench for fsm_pattern_serializer: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-of-line-bits reference model.
module tb_fsm_pattern_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       clr_hits = 1'b0;

  logic       load_ready, ser_out, ser_valid, done, hit;
  logic [7:0] seq_hits;
  logic       load_ready_s, ser_out_s, ser_valid_s, done_s, hit_s;
  logic [1:0] seq_hits_s;

  fsm_pattern_serializer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .ser_out(ser_out), .ser_valid(ser_valid), .done(done),
    .hit(hit), .seq_hits(seq_hits), .clr_hits(clr_hits)
  );

  fsm_pattern_serializer #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_s),
    .load_data(load_data), .ser_out(ser_out_s), .ser_valid(ser_valid_s), .done(done_s),
    .hit(hit_s), .seq_hits(seq_hits_s), .clr_hits(clr_hits)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model: bits still to appear on the line (front = bit on the line now),
  // the two previous line values, and the two hit counts
  bit q[$];
  bit p1, p2;
  int cnt_big, cnt_small;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_line();
    return (q.size() > 0) ? q[0] : 1'b0;
  endfunction

  function automatic bit m_hit();
    return p2 && !p1 && m_line();
  endfunction

  task automatic m_clear();
    q.delete();
    p1 = 1'b0;
    p2 = 1'b0;
    cnt_big = 0;
    cnt_small = 0;
  endtask

  task automatic check_outputs();
    chk("ser_out",    {31'd0, ser_out},    {31'd0, m_line()});
    chk("ser_valid",  {31'd0, ser_valid},  {31'd0, q.size() > 0});
    chk("done",       {31'd0, done},       {31'd0, q.size() == 1});
    chk("load_ready", {31'd0, load_ready}, {31'd0, q.size() <= 1});
    chk("hit",        {31'd0, hit},        {31'd0, m_hit()});
    chk("seq_hits",   {24'd0, seq_hits},   cnt_big);
    chk("hit_s",      {31'd0, hit_s},      {31'd0, m_hit()});
    chk("seq_hits_s", {30'd0, seq_hits_s}, cnt_small);
  endtask

  task automatic m_edge(input bit v, input bit [7:0] d, input bit c);
    bit h, cur, acc;
    h   = m_hit();
    cur = m_line();
    acc = v && (q.size() <= 1);
    if (c) begin
      cnt_big = 0;
      cnt_small = 0;
    end else if (h) begin
      if (cnt_big < 255) cnt_big++;
      if (cnt_small < 3) cnt_small++;
    end
    p2 = p1;
    p1 = cur;
    if (q.size() > 0) void'(q.pop_front());
    if (acc) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
  endtask

  // called at a falling edge; drives inputs, checks this cycle, advances one clock
  task automatic cycle(input bit v, input bit [7:0] d, input bit c);
    load_valid = v;
    load_data  = d;
    clr_hits   = c;
    check_outputs();
    @(posedge clk);
    m_edge(v, d, c);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // asynchronous assertion between edges, released at a falling edge
  task automatic do_reset();
    load_valid = 1'b0;
    clr_hits   = 1'b0;
    #2 reset = 1'b0;
    #1;
    m_clear();
    chk("rst_ser_valid",  {31'd0, ser_valid},  32'd0);
    chk("rst_ser_out",    {31'd0, ser_out},    32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_seq_hits",   {24'd0, seq_hits},   32'd0);
    check_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(2);

    // single word 1010_1000: hits at bits 3 and 5
    cycle(1'b1, 8'b1010_1000, 1'b0);
    idle(8);
    chk("t1_hits", {24'd0, seq_hits}, 32'd2);
    idle(2);

    // back-to-back words, hit straddles the boundary
    do_reset();
    cycle(1'b1, 8'b0000_0101, 1'b0);
    idle(7);
    cycle(1'b1, 8'b0100_0000, 1'b0);
    idle(8);
    chk("t2_hits", {24'd0, seq_hits}, 32'd2);

    // idle 0 between words completes 1,0,1
    do_reset();
    cycle(1'b1, 8'b0000_0001, 1'b0);
    idle(8);
    cycle(1'b1, 8'b1000_0000, 1'b0);
    idle(8);
    chk("t3_hits", {24'd0, seq_hits}, 32'd1);

    // saturation of the 2-bit counter
    do_reset();
    cycle(1'b1, 8'b1010_1010, 1'b0);
    idle(7);
    cycle(1'b1, 8'b1000_0000, 1'b0);
    idle(8);
    chk("t4_sat_small", {30'd0, seq_hits_s}, 32'd3);
    chk("t4_big",       {24'd0, seq_hits},   32'd4);

    // clear in the same cycle as a hit wins
    do_reset();
    cycle(1'b1, 8'b1010_1000, 1'b0);
    idle(4);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t5_clr", {24'd0, seq_hits}, 32'd0);
    idle(4);

    // reset mid-word, then a clean restart
    cycle(1'b1, 8'b1010_1000, 1'b0);
    idle(3);
    do_reset();
    cycle(1'b1, 8'b1011_0101, 1'b0);
    idle(9);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
